btn_event_arbiter: RTL

BTN_EVENT_ARBITER -- requirements
Module: btn_event_arbiter

---
 rtl/seg7_fun_pkg.sv | 17 +
 rtl/btn_debounce_cell.sv | 48 ++++
 rtl/btn_event_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/seg7_fun_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_fun_pkg : shared constants and arbiter state type for the        |
// |                button event arbiter.            Rev 1.0 initial      |
// +----------------------------------------------------------------------+
package seg7_fun_pkg;

  localparam int NUM_BTN   = 4;
  localparam int BTN_IDX_W = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/btn_debounce_cell.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_debounce_cell : 2-flop synchronizer plus stable-count debouncer.  |
// |                                                 Rev 1.0 initial      |
// +----------------------------------------------------------------------+
module btn_debounce_cell #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int                CNT_W    = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             w_sync;

  assign w_sync = r_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], raw};
    end
  end

  // Any cycle that agrees with the accepted level restarts the stability count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      level <= 1'b0;
    end else if (w_sync == level) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      level <= w_sync;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/btn_event_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_event_arbiter : debounced press events, round-robin handed off    |
// |                     over a valid/ready port.        Rev 1.0 initial   |
// +----------------------------------------------------------------------+
module btn_event_arbiter #(
  parameter int DEB_CYCLES = 4,
  parameter int NUM_BTN    = seg7_fun_pkg::NUM_BTN
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                ena,
  input  logic [NUM_BTN-1:0]                  btn_raw,
  output logic [NUM_BTN-1:0]                  btn_level,
  output logic [NUM_BTN-1:0]                  pending,
  output logic                                evt_valid,
  input  logic                                evt_ready,
  output logic [seg7_fun_pkg::BTN_IDX_W-1:0]  evt_id,
  output logic                                overflow
);

  import seg7_fun_pkg::*;

  arb_state_t             r_state;
  logic [BTN_IDX_W-1:0]   r_last_grant;
  logic [BTN_IDX_W-1:0]   w_winner;
  logic [NUM_BTN-1:0]     r_level_d;
  logic [NUM_BTN-1:0]     w_rise;
  logic [NUM_BTN-1:0]     w_hs_mask;
  logic                   w_hs;
  logic                   w_found;
  int                     w_idx;

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      btn_debounce_cell #(
        .DEB_CYCLES (DEB_CYCLES)
      ) u_cell (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_raw[gi]),
        .level (btn_level[gi])
      );
    end
  endgenerate

  assign w_rise    = btn_level & ~r_level_d;
  assign w_hs      = (r_state == ST_OFFER) && evt_ready;
  assign evt_valid = (r_state == ST_OFFER);

  always_comb begin
    w_hs_mask = '0;
    if (w_hs) begin
      w_hs_mask[evt_id] = 1'b1;
    end
  end

  // Search starts one past the last grant so every button gets a turn.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_idx    = 0;
    for (int k = 1; k <= NUM_BTN; k++) begin
      w_idx = (int'(r_last_grant) + k) % NUM_BTN;
      if (!w_found && pending[w_idx]) begin
        w_winner = BTN_IDX_W'(w_idx);
        w_found  = 1'b1;
      end
    end
  end

  // A press landing on the button being handed off is a fresh event, not a loss.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level_d <= '0;
      pending   <= '0;
      overflow  <= 1'b0;
    end else begin
      r_level_d <= btn_level;
      pending   <= (pending & ~w_hs_mask) | w_rise;
      if (|(w_rise & pending & ~w_hs_mask)) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= BTN_IDX_W'(NUM_BTN - 1);
      evt_id       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ena && (|pending)) begin
            r_state <= ST_OFFER;
            evt_id  <= w_winner;
          end
        end
        ST_OFFER: begin
          if (evt_ready) begin
            r_state      <= ST_IDLE;
            r_last_grant <= evt_id;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
